// File: rtl/div_share_arbiter_if.sv
// Bundle of requester-side and divider-side signals around the shared divider
// arbiter.
//   slave  : the arbiter. It takes req/x/y and divider responses, and drives the
//            acks, results and divider commands.
//   master : the environment, meaning the requesters plus the divider unit.
// Requester side : req0/req1, x0/y0/x1/y1 -> ack0/ack1, q_out, r_out, err_out,
//                  tmo_out, busy
// Divider side   : div_go, div_x, div_y -> div_done, div_err, div_q, div_r
interface div_share_arbiter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] y1;
    logic             ack0;
    logic             ack1;
    logic [WIDTH-1:0] q_out;
    logic [WIDTH-1:0] r_out;
    logic             err_out;
    logic             tmo_out;
    logic             busy;
    logic             div_go;
    logic [WIDTH-1:0] div_x;
    logic [WIDTH-1:0] div_y;
    logic             div_done;
    logic             div_err;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;

    modport slave (
        input  req0, req1, x0, y0, x1, y1, div_done, div_err, div_q, div_r,
        output ack0, ack1, q_out, r_out, err_out, tmo_out, busy, div_go, div_x, div_y
    );

    modport master (
        output req0, req1, x0, y0, x1, y1, div_done, div_err, div_q, div_r,
        input  ack0, ack1, q_out, r_out, err_out, tmo_out, busy, div_go, div_x, div_y
    );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin arbiter that shares one sequential divider between two requesters.
// It latches the winner's operands, pulses div_go, and waits for div_done. A
// watchdog bounds that wait. The result is then returned with a one-cycle ack.
// Ports:
//   CLK : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : div_share_arbiter_if.slave carrying the requester and divider signals
// Every output is registered. The q/r/err/tmo results hold from one RESP to the
// next.
module div_share_arbiter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned TIMEOUT = 31  // 1..255
) (
    input logic                CLK,
    input logic                rst,
    div_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

    localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

    state_t           state;
    logic             gnt;
    logic             last;
    logic [7:0]       wd;
    logic             winner;

    logic             ack0_q;
    logic             ack1_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic             err_q;
    logic             tmo_q;
    logic             busy_q;
    logic             go_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;

    // On a tie the requester that was not served last wins. A lone request
    // always wins.
    always_comb begin
        winner = bus.req1;
        if (bus.req0 && bus.req1) begin
            winner = ~last;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            gnt    <= 1'b0;
            last   <= 1'b1;
            wd     <= 8'd0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            q_q    <= '0;
            r_q    <= '0;
            err_q  <= 1'b0;
            tmo_q  <= 1'b0;
            busy_q <= 1'b0;
            go_q   <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.req0 || bus.req1) begin
                        gnt    <= winner;
                        x_q    <= winner ? bus.x1 : bus.x0;
                        y_q    <= winner ? bus.y1 : bus.y0;
                        go_q   <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= StIssue;
                    end
                end
                StIssue: begin
                    go_q  <= 1'b0;
                    wd    <= 8'd0;
                    state <= StWait;
                end
                StWait: begin
                    wd <= wd + 8'd1;
                    // Done takes priority over the watchdog firing on the same edge.
                    if (bus.div_done) begin
                        q_q    <= bus.div_q;
                        r_q    <= bus.div_r;
                        err_q  <= bus.div_err;
                        tmo_q  <= 1'b0;
                        ack0_q <= ~gnt;
                        ack1_q <= gnt;
                        state  <= StResp;
                    end else if (wd == WdLast) begin
                        q_q    <= '0;
                        r_q    <= '0;
                        err_q  <= 1'b1;
                        tmo_q  <= 1'b1;
                        ack0_q <= ~gnt;
                        ack1_q <= gnt;
                        state  <= StResp;
                    end
                end
                StResp: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    last   <= gnt;
                    busy_q <= 1'b0;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.q_out   = q_q;
    assign bus.r_out   = r_q;
    assign bus.err_out = err_q;
    assign bus.tmo_out = tmo_q;
    assign bus.busy    = busy_q;
    assign bus.div_go  = go_q;
    assign bus.div_x   = x_q;
    assign bus.div_y   = y_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Scoreboard bench for div_share_arbiter. The stimulus pushes one expected
// result per transaction. The monitor pops and compares on every ack. A
// behavioural divider with a programmable latency and a hang mode answers
// div_go.
module tb_div_share_arbiter;
    localparam int unsigned W   = 4;
    localparam int unsigned TMO = 31;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    always #5 CLK = ~CLK;

    div_share_arbiter_if #(.WIDTH(W)) bus ();

    div_share_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic         who;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         err;
        logic         tmo;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   gos         = 0;
    int   cyc         = 0;
    int   lat         = 10;
    logic hang        = 1'b0;

    // Behavioural divider: Done arrives lat+1 cycles after the Go cycle.
    logic         m_busy;
    int           m_cnt;
    logic [W-1:0] m_x, m_y;
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            bus.div_done <= 1'b0;
            bus.div_err  <= 1'b0;
            bus.div_q    <= '0;
            bus.div_r    <= '0;
            m_busy       <= 1'b0;
            m_cnt        <= 0;
            m_x          <= '0;
            m_y          <= '0;
        end else begin
            bus.div_done <= 1'b0;
            if (bus.div_go) begin
                m_busy <= 1'b1;
                m_cnt  <= lat - 1;
                m_x    <= bus.div_x;
                m_y    <= bus.div_y;
            end else if (m_busy && !hang) begin
                if (m_cnt == 0) begin
                    m_busy       <= 1'b0;
                    bus.div_done <= 1'b1;
                    bus.div_err  <= (m_y == '0);
                    bus.div_q    <= (m_y == '0) ? '0 : m_x / m_y;
                    bus.div_r    <= (m_y == '0) ? '0 : m_x % m_y;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    initial forever begin
        @(posedge CLK);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act != exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic who, input int q, input int r, input logic err,
                        input logic tmo);
        exp_t e;
        e.who = who;
        e.q   = W'(q);
        e.r   = W'(r);
        e.err = err;
        e.tmo = tmo;
        sb.push_back(e);
    endtask

    // Monitor: compares each ack against the oldest expectation.
    initial forever begin
        @(negedge CLK);
        if (!rst) begin
            if (bus.div_go) gos = gos + 1;
            if (bus.ack0 || bus.ack1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_onehot", int'(bus.ack0 & bus.ack1), 0);
                    chk("ack_who", int'(bus.ack1), int'(e.who));
                    chk("q_out", int'(bus.q_out), int'(e.q));
                    chk("r_out", int'(bus.r_out), int'(e.r));
                    chk("err_out", int'(bus.err_out), int'(e.err));
                    chk("tmo_out", int'(bus.tmo_out), int'(e.tmo));
                end
            end
        end
    end

    // Wait for n acks. Requests drop on their ack unless hold is set.
    task automatic run_until(input int n, input int budget, input string name, input bit hold,
                             output int ack_cyc);
        int seen = 0;
        int k    = 0;
        ack_cyc = 0;
        while (seen < n) begin
            @(negedge CLK);
            k = k + 1;
            if (bus.ack0 || bus.ack1) begin
                seen    = seen + 1;
                ack_cyc = cyc;
            end
            if (bus.ack0 && !hold) bus.req0 = 1'b0;
            if (bus.ack1 && !hold) bus.req1 = 1'b0;
            if (seen < n && k >= budget) begin
                chk({name, "_ack_timeout"}, seen, n);
                break;
            end
        end
    endtask

    task automatic wait_go(input string name, output int go_cyc);
        int k = 0;
        go_cyc = 0;
        while (!bus.div_go) begin
            @(negedge CLK);
            k = k + 1;
            if (k > 20) begin
                chk({name, "_go_timeout"}, 0, 1);
                break;
            end
        end
        go_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        int g0, gc, ac;
        #600000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int g0, gc, ac;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
        idle(3);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_go", int'(bus.div_go), 0);
        chk("rst_acks", int'({bus.ack0, bus.ack1}), 0);
        chk("rst_q", int'(bus.q_out), 0);
        chk("rst_err", int'({bus.err_out, bus.tmo_out}), 0);
        chk("rst_xy", int'({bus.div_x, bus.div_y}), 0);
        rst = 1'b0;
        idle(2);

        // T1: single request; a short req1 pulse while busy must be ignored.
        g0 = gos; lat = 10;
        bus.req0 = 1'b1; bus.x0 = 4'd7; bus.y0 = 4'd2;
        push(1'b0, 3, 1, 1'b0, 1'b0);
        wait_go("t1", gc);
        chk("t1_div_x", int'(bus.div_x), 7);
        idle(2);
        bus.req1 = 1'b1; bus.x1 = 4'd9; bus.y1 = 4'd1;
        idle(2);
        bus.req1 = 1'b0;
        run_until(1, 60, "t1", 1'b0, ac);
        idle(4);
        chk("t1_go_count", gos - g0, 1);
        chk("t1_hold_q", int'(bus.q_out), 3);
        chk("t1_idle_busy", int'(bus.busy), 0);

        // T2: simultaneous requests after reset, so req0 wins the first tie.
        do_reset();
        g0 = gos;
        bus.x0 = 4'd9; bus.y0 = 4'd4; bus.x1 = 4'd8; bus.y1 = 4'd3;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        push(1'b0, 2, 1, 1'b0, 1'b0);
        push(1'b1, 2, 2, 1'b0, 1'b0);
        run_until(2, 100, "t2", 1'b0, ac);
        idle(3);
        chk("t2_go_count", gos - g0, 2);

        // T3: both held for four transactions, so the grants alternate 0,1,0,1.
        g0 = gos; lat = 3;
        bus.x0 = 4'd13; bus.y0 = 4'd4; bus.x1 = 4'd15; bus.y1 = 4'd2;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        push(1'b0, 3, 1, 1'b0, 1'b0);
        push(1'b1, 7, 1, 1'b0, 1'b0);
        push(1'b0, 3, 1, 1'b0, 1'b0);
        push(1'b1, 7, 1, 1'b0, 1'b0);
        run_until(4, 200, "t3", 1'b1, ac);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        idle(3);
        chk("t3_go_count", gos - g0, 4);

        // T4: divide by zero; req dropped and operands changed after grant.
        g0 = gos; lat = 2;
        bus.req1 = 1'b1; bus.x1 = 4'd5; bus.y1 = 4'd0;
        push(1'b1, 0, 0, 1'b1, 1'b0);
        wait_go("t4", gc);
        bus.req1 = 1'b0; bus.y1 = 4'd3;
        run_until(1, 40, "t4", 1'b0, ac);
        idle(3);
        chk("t4_go_count", gos - g0, 1);

        // T5: divider hangs, so the watchdog fires and ack lands 32 cycles after Go.
        hang = 1'b1;
        bus.req0 = 1'b1; bus.x0 = 4'd6; bus.y0 = 4'd3;
        push(1'b0, 0, 0, 1'b1, 1'b1);
        wait_go("t5", gc);
        run_until(1, 60, "t5", 1'b0, ac);
        chk("t5_latency", ac - gc, 32);
        @(negedge CLK);
        chk("t5_busy_low", int'(bus.busy), 0);
        hang = 1'b0;
        do_reset();

        // Done on the same edge as the watchdog: done wins.
        lat = 30;
        bus.req0 = 1'b1; bus.x0 = 4'd14; bus.y0 = 4'd3;
        push(1'b0, 4, 2, 1'b0, 1'b0);
        wait_go("t5b", gc);
        run_until(1, 60, "t5b", 1'b0, ac);
        chk("t5b_latency", ac - gc, 32);

        // One cycle too late: timeout. The late Done then lands in RESP and is ignored.
        lat = 31;
        bus.req1 = 1'b1; bus.x1 = 4'd11; bus.y1 = 4'd5;
        push(1'b1, 0, 0, 1'b1, 1'b1);
        run_until(1, 60, "t5c", 1'b0, ac);
        idle(4);
        chk("t5c_hold_tmo", int'(bus.tmo_out), 1);

        // T6: reset in WAIT cycle 3 aborts the transaction. The next request works.
        g0 = gos; lat = 10;
        bus.req0 = 1'b1; bus.x0 = 4'd7; bus.y0 = 4'd3;
        wait_go("t6", gc);
        idle(3);
        rst = 1'b1; bus.req0 = 1'b0;
        #1;
        chk("t6_rst_busy", int'(bus.busy), 0);
        chk("t6_rst_go", int'(bus.div_go), 0);
        chk("t6_rst_acks", int'({bus.ack0, bus.ack1}), 0);
        idle(2);
        rst = 1'b0;
        idle(2);
        bus.req0 = 1'b1; bus.x0 = 4'd12; bus.y0 = 4'd5;
        push(1'b0, 2, 2, 1'b0, 1'b0);
        run_until(1, 60, "t6", 1'b0, ac);
        idle(5);
        chk("t6_go_count", gos - g0, 2);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
